// File: rtl/debounce_pulse_module.sv
// debounce_pulse_module
// Cleans up a bouncing push-button for use as the clock of the 4-bit ripple
// counter. The raw button passes through a two-flop synchroniser. A
// stable-time counter FSM then debounces it. The block drives a registered
// debounced level, plus a one-cycle pulse for each accepted press.
//
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat pulses
// while the button stays pressed. The first repeat comes after REPEAT_DELAY
// cycles in PRESSED, and later repeats come every REPEAT_PERIOD cycles. With
// the macro undefined, no repeat logic is built, and each press gives
// exactly one pulse.

module debounce_pulse_module #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level_out,
    output logic pulse_out
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    // Counters never pass their terminal value, so each parameter must fit in CNT_WIDTH bits.
    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_WIDTH;
    localparam bit PARAMS_OK = (STABLE_CYCLES >= 1) && (REPEAT_DELAY >= 1) &&
                               (REPEAT_PERIOD >= 1) &&
                               (longint'(STABLE_CYCLES) < CNT_RANGE) &&
                               (longint'(REPEAT_DELAY)  < CNT_RANGE) &&
                               (longint'(REPEAT_PERIOD) < CNT_RANGE);

    // Reject illegal parameter sets at elaboration time.
    if (!PARAMS_OK) begin : g_bad_params
        $error("debounce_pulse_module: illegal STABLE_CYCLES/REPEAT_*/CNT_WIDTH combination");
    end

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sync1_q, sync1_d;
    logic                 s_q, s_d;
    logic                 level_q, level_d;
    logic                 pulse_q, pulse_d;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
    logic                 first_q, first_d;   // 1: waiting for the first repeat
    logic [CNT_WIDTH-1:0] rep_last;
`endif

    // Next-state, counter and output logic for the debounce FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        sync1_d = btn_in;
        s_d     = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rep_cnt_d = rep_cnt_q;
        first_d   = first_q;
        rep_last  = first_q ? DELAY_LAST : PERIOD_LAST;
`endif
        unique case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
`endif
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s_q) begin
                    // The repeat count is frozen here and resumes if the release bounces back.
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    if (rep_cnt_q == rep_last) begin
                        pulse_d   = 1'b1;
                        rep_cnt_d = '0;
                        first_d   = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
`endif
                end
            end
            WAIT_RELEASE: begin
                if (s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchroniser, FSM and output registers with a synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop samples the values from before the edge.
        if (rst) begin
            // NOTE: the synchroniser flops are reset too, so a button held through reset must debounce again from zero.
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Auto-repeat counter and first/subsequent flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            first_q   <= 1'b1;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            first_q   <= first_d;
        end
    end
`endif

    assign level_out = level_q;
    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_debounce_pulse_module.sv
// Directed bench for debounce_pulse_module with its default parameters
// (STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3). Expected pulse counts
// depend on DEBOUNCE_AUTOREPEAT_EN, so they are selected at compile time.
// Outputs are sampled 1 ns after each rising edge. Inputs change at that
// point, and each input value is first seen by sync1 at the next edge.

module tb_debounce_pulse_module;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic level_out;
    logic pulse_out;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   tick_no = 0;
    int   pulse_tot = 0;
    int   level_hi = 0;
    logic prev_pulse = 1'b0;
    int   pulse_log[$];

    debounce_pulse_module dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .level_out (level_out),
        .pulse_out (pulse_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: sample after the edge, log pulses, and track level-high cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        check("pulse_width", {31'd0, prev_pulse & pulse_out}, 32'd0);
        if (pulse_out === 1'b1) begin
            pulse_tot++;
            pulse_log.push_back(tick_no);
        end
        if (level_out === 1'b1) level_hi++;
        prev_pulse = pulse_out;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        tick_no   = 0;
        pulse_tot = 0;
        level_hi  = 0;
        pulse_log.delete();
    endtask

    int exp_log[$];
    int got_v;
    int exp_press_pulses;

    initial begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
        exp_press_pulses = 4;
        exp_log = '{7, 15, 18, 21, 24, 27, 30, 33, 36};
`else
        exp_press_pulses = 1;
        exp_log = '{7};
`endif
        // 1: reset with the button held, then the latency of the first press.
        rst    = 1'b1;
        btn_in = 1'b1;
        tick();
        check("t1_rst_level_0", {31'd0, level_out}, 32'd0);
        check("t1_rst_pulse_0", {31'd0, pulse_out}, 32'd0);
        tick();
        check("t1_rst_level_1", {31'd0, level_out}, 32'd0);
        check("t1_rst_pulse_1", {31'd0, pulse_out}, 32'd0);
        rst = 1'b0;
        clear_stats();
        ticks(6);                           // edges k .. k+5
        check("t1_level_k5", {31'd0, level_out}, 32'd0);
        check("t1_pulse_k5", {31'd0, pulse_out}, 32'd0);
        tick();                             // edge k+6
        check("t1_level_k6", {31'd0, level_out}, 32'd1);
        check("t1_pulse_k6", {31'd0, pulse_out}, 32'd1);
        tick();                             // edge k+7
        check("t1_level_k7", {31'd0, level_out}, 32'd1);
        check("t1_pulse_k7", {31'd0, pulse_out}, 32'd0);

        // Release: the level falls 6 edges after the first 0 sample, with no pulse.
        clear_stats();
        btn_in = 1'b0;
        ticks(6);
        check("t1_rel_level_j5", {31'd0, level_out}, 32'd1);
        tick();
        check("t1_rel_level_j6", {31'd0, level_out}, 32'd0);
        ticks(5);
        check("t1_rel_pulses", pulse_tot, 0);

        // 2: clean press of 20 cycles, then 20 cycles released.
        clear_stats();
        btn_in = 1'b1;
        ticks(20);
        btn_in = 1'b0;
        ticks(20);
        check("t2_pulses", pulse_tot, exp_press_pulses);
        check("t2_first_pulse_tick", (pulse_log.size() > 0) ? pulse_log[0] : -1, 7);
        check("t2_level_high_cycles", level_hi, 20);
        check("t2_level_end", {31'd0, level_out}, 32'd0);

        // 3: press bounce 1,1,1,0 repeated five times gives no output.
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            btn_in = 1'b1;
            ticks(3);
            btn_in = 1'b0;
            tick();
        end
        ticks(10);
        check("t3_pulses", pulse_tot, 0);
        check("t3_level_high_cycles", level_hi, 0);

        // 4: release bounce while pressed holds the level, then a real release.
        clear_stats();
        btn_in = 1'b1;
        ticks(10);
        check("t4_level_pressed", {31'd0, level_out}, 32'd1);
        check("t4_press_pulses", pulse_tot, 1);
        pulse_tot = 0;
        level_hi  = 0;
        btn_in = 1'b0;
        ticks(2);                           // ticks 11-12
        btn_in = 1'b1;
        ticks(3);                           // ticks 13-15
        btn_in = 1'b0;
        ticks(6);                           // ticks 16-21
        check("t4_level_held_cycles", level_hi, 11);
        check("t4_bounce_pulses", pulse_tot, 0);
        tick();                             // tick 22 = 6 edges after the first 0 at tick 16
        check("t4_level_fall", {31'd0, level_out}, 32'd0);
        ticks(5);

        // 5: reset in WAIT_PRESS with the button held, then a fresh full debounce.
        clear_stats();
        btn_in = 1'b1;
        ticks(4);
        check("t5_level_waitpress", {31'd0, level_out}, 32'd0);
        rst = 1'b1;
        tick();
        check("t5_rst_level", {31'd0, level_out}, 32'd0);
        check("t5_rst_pulse", {31'd0, pulse_out}, 32'd0);
        rst = 1'b0;
        tick_no = 0;
        ticks(6);
        check("t5_level_k5", {31'd0, level_out}, 32'd0);
        tick();
        check("t5_level_k6", {31'd0, level_out}, 32'd1);
        check("t5_pulse_k6", {31'd0, pulse_out}, 32'd1);
        ticks(3);
        btn_in = 1'b0;
        ticks(10);
        check("t5_total_pulses", pulse_tot, 1);

        // 6: long hold of 35 cycles shows the repeat behaviour (or its absence).
        clear_stats();
        btn_in = 1'b1;
        ticks(35);
        btn_in = 1'b0;
        ticks(20);
        check("t6_pulse_count", pulse_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            got_v = (i < pulse_log.size()) ? pulse_log[i] : -1;
            check($sformatf("t6_pulse_tick_%0d", i), got_v, exp_log[i]);
        end
        check("t6_level_end", {31'd0, level_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
